// File: rtl/alarm_timer.sv
// alarm_timer: programmable countdown stage of the car-alarm datapath.
// Holds four interval lengths, loads the selected one on Start_Timer and
// counts down once per one_hz_enable tick, pulsing Expired on completion.
module alarm_timer #(
  parameter int unsigned VAL_W            = 4,
  parameter int unsigned T_ARM_DEFAULT    = 6,
  parameter int unsigned T_DRIVER_DEFAULT = 8,
  parameter int unsigned T_PASSENGER_DEFAULT = 15,
  parameter int unsigned T_ALARM_DEFAULT  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             one_hz_enable,
  input  logic             Start_Timer,
  input  logic [1:0]       Interval,
  input  logic             Reprogram,
  input  logic [1:0]       Time_Param_Sel,
  input  logic [VAL_W-1:0] Time_Value,
  output logic             Expired,
  output logic             Busy,
  output logic [VAL_W-1:0] Time_Left
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] bank [4];
  logic [VAL_W-1:0] load_val;

  // Interval selected for a start; reads the bank before any same-cycle write
  always_comb begin
    load_val = bank[Interval];
  end

  // Parameter bank writes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank[0] <= VAL_W'(T_ARM_DEFAULT);
      bank[1] <= VAL_W'(T_DRIVER_DEFAULT);
      bank[2] <= VAL_W'(T_PASSENGER_DEFAULT);
      bank[3] <= VAL_W'(T_ALARM_DEFAULT);
    end else if (Reprogram) begin
      bank[Time_Param_Sel] <= Time_Value;
    end
  end

  // Countdown FSM with registered outputs; Start_Timer outranks the tick
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      Time_Left <= '0;
      Busy      <= 1'b0;
      Expired   <= 1'b0;
    end else begin
      Expired <= 1'b0;
      if (Start_Timer) begin
        if (load_val != '0) begin
          Time_Left <= load_val;
          state     <= RUN;
          Busy      <= 1'b1;
        end else begin
          Time_Left <= '0;
          Expired   <= 1'b1;
          state     <= IDLE;
          Busy      <= 1'b0;
        end
      end else if (state == RUN && one_hz_enable) begin
        // Count is never 0 while running, so <=1 covers the final tick
        if (Time_Left > VAL_W'(1)) begin
          Time_Left <= Time_Left - VAL_W'(1);
        end else begin
          Time_Left <= '0;
          Expired   <= 1'b1;
          state     <= IDLE;
          Busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Directed self-checking bench for alarm_timer.
module tb_alarm_timer;

  logic       clk;
  logic       reset_n;
  logic       one_hz_enable;
  logic       Start_Timer;
  logic [1:0] Interval;
  logic       Reprogram;
  logic [1:0] Time_Param_Sel;
  logic [3:0] Time_Value;
  logic       Expired;
  logic       Busy;
  logic [3:0] Time_Left;

  int unsigned n_checks;
  int unsigned n_errors;

  alarm_timer #(
    .VAL_W(4),
    .T_ARM_DEFAULT(6),
    .T_DRIVER_DEFAULT(8),
    .T_PASSENGER_DEFAULT(15),
    .T_ALARM_DEFAULT(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .one_hz_enable(one_hz_enable),
    .Start_Timer(Start_Timer),
    .Interval(Interval),
    .Reprogram(Reprogram),
    .Time_Param_Sel(Time_Param_Sel),
    .Time_Value(Time_Value),
    .Expired(Expired),
    .Busy(Busy),
    .Time_Left(Time_Left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge; outputs are stable 1 time unit later, strobes then drop
  task automatic cycle();
    @(posedge clk);
    #1;
    one_hz_enable  = 1'b0;
    Start_Timer    = 1'b0;
    Reprogram      = 1'b0;
  endtask

  task automatic start(input logic [1:0] iv);
    Interval    = iv;
    Start_Timer = 1'b1;
    cycle();
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    cycle();
  endtask

  task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
    Time_Param_Sel = sel;
    Time_Value     = val;
    Reprogram      = 1'b1;
    cycle();
  endtask

  task automatic outs(input string tag, input logic [3:0] tl,
                      input logic b, input logic e);
    check({tag, ".tl"}, 32'(Time_Left), 32'(tl));
    check({tag, ".busy"}, 32'(Busy), 32'(b));
    check({tag, ".exp"}, 32'(Expired), 32'(e));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    one_hz_enable  = 1'b0;
    Start_Timer    = 1'b0;
    Interval       = 2'd0;
    Reprogram      = 1'b0;
    Time_Param_Sel = 2'd0;
    Time_Value     = 4'd0;

    // Reset state
    cycle();
    cycle();
    outs("reset", 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Ticks in IDLE are ignored
    tick();
    outs("idle_tick", 4'd0, 1'b0, 1'b0);

    // Interval 1 default 8, full countdown
    start(2'd1);
    outs("start1", 4'd8, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) outs("cnt1", 4'(8 - i), 1'b1, 1'b0);
      else       outs("last1", 4'd0, 1'b0, 1'b1);
    end
    cycle();
    outs("exp_drop", 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    outs("no_wrap", 4'd0, 1'b0, 1'b0);

    // Reprogram entry 2 to 3
    reprog(2'd2, 4'd3);
    start(2'd2);
    outs("start2r", 4'd3, 1'b1, 1'b0);
    tick();
    outs("cnt2a", 4'd2, 1'b1, 1'b0);
    tick();
    outs("cnt2b", 4'd1, 1'b1, 1'b0);
    tick();
    outs("last2", 4'd0, 1'b0, 1'b1);
    start(2'd0);
    outs("start0", 4'd6, 1'b1, 1'b0);

    // Write during a run leaves the countdown alone; zero-length start
    reprog(2'd3, 4'd0);
    outs("wr_run", 4'd6, 1'b1, 1'b0);
    start(2'd3);
    outs("zero", 4'd0, 1'b0, 1'b1);
    cycle();
    outs("zero_drop", 4'd0, 1'b0, 1'b0);

    // Restart with a same-cycle tick: tick dropped
    start(2'd0);
    tick();
    tick();
    outs("pre_rst", 4'd4, 1'b1, 1'b0);
    Interval      = 2'd1;
    Start_Timer   = 1'b1;
    one_hz_enable = 1'b1;
    cycle();
    outs("restart", 4'd8, 1'b1, 1'b0);

    // Same-cycle write and start use the pre-write value
    Time_Param_Sel = 2'd1;
    Time_Value     = 4'd2;
    Reprogram      = 1'b1;
    Interval       = 2'd1;
    Start_Timer    = 1'b1;
    cycle();
    outs("wr_start", 4'd8, 1'b1, 1'b0);
    start(2'd1);
    outs("new_val", 4'd2, 1'b1, 1'b0);

    // Reset mid-countdown aborts without Expired and restores defaults
    reprog(2'd2, 4'd9);
    start(2'd2);
    outs("start2n", 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    outs("cnt5", 4'd4, 1'b1, 1'b0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    outs("abort", 4'd0, 1'b0, 1'b0);
    tick();
    outs("abort_tick", 4'd0, 1'b0, 1'b0);
    start(2'd2);
    outs("dflt2", 4'd15, 1'b1, 1'b0);
    start(2'd3);
    outs("dflt3", 4'd10, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_timer.md
# alarm_timer

Countdown timer stage of the Lab4 car-alarm datapath: consumes the `one_hz_enable` tick produced by the 1 Hz divider and the same `Start_Timer` strobe that resets that divider. It holds a bank of four programmable interval lengths, loads the selected one on `Start_Timer`, and decrements once per tick. When the count reaches zero it emits a one-cycle `Expired` pulse to the alarm FSM. The remaining time is exported for the seven-segment display.

## Interface
- `VAL_W`, 4: width of interval values and the count, in seconds.
- `T_ARM_DEFAULT`, 6: reset value of interval 0 (arming delay).
- `T_DRIVER_DEFAULT`, 8: reset value of interval 1 (driver-door delay).
- `T_PASSENGER_DEFAULT`, 15: reset value of interval 2 (passenger-door delay).
- `T_ALARM_DEFAULT`, 10: reset value of interval 3 (siren-on length).

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `one_hz_enable`  in  1  one-cycle tick from the divider, once per second.
- `Start_Timer`  in  1  one-cycle strobe that loads the selected interval and starts the countdown.
- `Interval`  in  2  index of the interval to load on `Start_Timer`.
- `Reprogram`  in  1  one-cycle strobe that writes `Time_Value` into the parameter bank at `Time_Param_Sel`.
- `Time_Param_Sel`  in  2  parameter-bank write index.
- `Time_Value`  in  VAL_W  value written on `Reprogram`.
- `Expired`  out  1  one-cycle pulse when the countdown completes.
- `Busy`  out  1  high while a countdown is in progress.
- `Time_Left`  out  VAL_W  current count, for display.

## Operation
- Parameter bank: four VAL_W-bit registers, loaded with the `*_DEFAULT` values on reset.
  - `Reprogram` writes `Time_Value` into entry `Time_Param_Sel`.
  - A value of 0 is legal.
  - A write never alters a countdown already in progress.
- State machine has two states, IDLE and RUN.
- IDLE:
  - `Start_Timer` with `param[Interval]` nonzero: `Time_Left <= param[Interval]`, go to RUN.
  - `Start_Timer` with `param[Interval]` == 0: `Time_Left <= 0`, pulse `Expired`, stay in IDLE.
  - `one_hz_enable` is ignored.
- RUN:
  - `one_hz_enable` with `Time_Left` > 1: decrement `Time_Left`.
  - `one_hz_enable` with `Time_Left` == 1: `Time_Left <= 0`, pulse `Expired`, go to IDLE.
- `Start_Timer` in RUN restarts the countdown using the same rules as in IDLE.
- Priority: `reset_n` low, then `Start_Timer`, then `one_hz_enable`.
  - A tick in the same cycle as `Start_Timer` is dropped.
- `Reprogram` and `Start_Timer` in the same cycle with `Time_Param_Sel` == `Interval`: the load uses the pre-write value; the new value applies from the next start.
- `Busy` is 1 exactly when the state is RUN.
- `Time_Left` holds at 0 in IDLE after expiry until the next start.
- No wrap-around: the count never decrements below 0.

## Timing
- Reset (`reset_n` low at a rising edge) sets, at that edge:
  - state IDLE;
  - `Time_Left` = 0, `Busy` = 0, `Expired` = 0;
  - bank = defaults.
- Reset mid-countdown aborts the countdown with no `Expired` pulse.
- All outputs are registered.
- `Start_Timer` sampled at edge k: `Time_Left` and `Busy` are valid after edge k.
- Tick sampled at edge k: the decremented `Time_Left` is visible after edge k.
- Final tick at edge k: after edge k, `Expired` = 1, `Busy` = 0 and `Time_Left` = 0. `Expired` returns to 0 after edge k+1.
- Zero-length start at edge k: `Expired` is high for the cycle after edge k.
- Because the divider restarts on the same `Start_Timer`, an interval N lasts N full seconds, ±1 clk.
- `Reprogram` at edge k: the new value is readable by a `Start_Timer` at edge k+1.

## Test plan
- Reset, then `Start_Timer` with `Interval`=1 → `Time_Left`=8 and `Busy`=1. Then 8 ticks → `Time_Left` goes 7…1, then 0. After the eighth tick: `Expired`=1 for one cycle, `Busy`=0. Extra ticks leave `Time_Left`=0.
- `Reprogram` `Time_Param_Sel`=2, `Time_Value`=3. Then start with `Interval`=2 → `Time_Left`=3, and `Expired` fires after the third tick. A start with `Interval`=0 still loads 6.
- `Reprogram` entry 3 to 0, then start `Interval`=3 → `Expired` for one cycle, `Busy` stays 0, `Time_Left`=0.
- Start interval 0 (6), give 2 ticks (`Time_Left`=4). Then `Start_Timer` with `Interval`=1 in the same cycle as a tick → `Time_Left`=8, not 7, and no `Expired`.
- Same-cycle `Reprogram` entry 1 to 2 and start `Interval`=1 → `Time_Left`=8. The next start on interval 1 → `Time_Left`=2.
- Start interval 2, 5 ticks, then `reset_n` low for one cycle → `Time_Left`=0, `Busy`=0, no `Expired`, and bank entry 2 reads back as 15 on the next start.
